// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button gesture decoder.
// Timing constants assume the 10 MHz TT system clock.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } gesture_state_t;

  localparam int unsigned DEB_10MS   = 100_000;
  localparam int unsigned LONG_500MS = 5_000_000;
  localparam int unsigned REP_100MS  = 1_000_000;

endpackage

// File: rtl/btn_conditioner.sv
// Raw button pin to clean level: optional inversion, synchronizer chain,
// then a debounce counter that only accepts a level that persists.
module btn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic held
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic                   btn_in;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [DW-1:0]          deb_cnt;

  assign btn_in   = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Chain clears to "not pressed" regardless of pin polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      held    <= 1'b0;
    end else if (btn_sync != held) begin
      if (deb_cnt == DEB_LAST) begin
        held    <= btn_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced presses into short / long / auto-repeat one-cycle
// pulses for the pattern logic. At most one pulse is high per cycle.
module button_gesture_decoder
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int LONG_CYCLES     = LONG_500MS,
  parameter int REPEAT_CYCLES   = REP_100MS,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic btn_raw,
  output logic held,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int HW = $clog2(LONG_CYCLES);
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  gesture_state_t state, state_d;
  logic [HW-1:0]  hold_cnt, hold_d;
  logic [RW-1:0]  rep_cnt, rep_d;
  logic           held_q, rise, fall;
  logic           short_d, long_d, repeat_d;

  btn_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_cond (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .held   (held)
  );

  // held_q tracks even while disabled so a press already in progress when
  // ena rises is not mistaken for a new rising edge.
  assign rise = held & ~held_q;
  assign fall = ~held & held_q;

  always_comb begin
    state_d  = state;
    hold_d   = hold_cnt;
    rep_d    = rep_cnt;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      hold_d  = '0;
      rep_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_d = PRESSED;
            hold_d  = '0;
          end
        end
        PRESSED: begin
          // A release on the terminal count still counts as short.
          if (fall) begin
            short_d = 1'b1;
            state_d = IDLE;
            hold_d  = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            long_d  = 1'b1;
            rep_d   = '0;
            state_d = LONG_HELD;
          end else begin
            hold_d = hold_cnt + HW'(1);
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state_d = IDLE;
            rep_d   = '0;
          end else if (rep_cnt == REP_LAST) begin
            repeat_d = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_cnt + RW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      held_q       <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_d;
      hold_cnt     <= hold_d;
      rep_cnt      <= rep_d;
      held_q       <= held;
      short_pulse  <= short_d;
      long_pulse   <= long_d;
      repeat_pulse <= repeat_d;
    end
  end

endmodule

// File: doc/button_gesture_decoder.md
Name: button_gesture_decoder

Overview:
- Input-conditioning stage that sits directly upstream of the seven-segment pattern/changing logic.
- Turns one raw, bouncy push-button pin into clean one-cycle event pulses: short press, long press and auto-repeat.
- The display logic consumes these pulses to step, jump or scroll patterns; this replaces ad-hoc per-button edge detection.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on the raw input (minimum 2).
- DEBOUNCE_CYCLES, 50000, consecutive cycles a new synchronized level must persist before it is accepted (minimum 2).
- LONG_CYCLES, 5000000, debounced-high cycles after which a press is classified as long (must be > DEBOUNCE_CYCLES).
- REPEAT_CYCLES, 1000000, period of repeat pulses while held after a long press (minimum 2).
- ACTIVE_LOW, 0, 1 = button pin reads 0 when pressed (inverted before synchronizing).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  block enable; low forces the FSM idle and suppresses all pulses.
- btn_raw  in  1  raw button pin, asynchronous to clk.
- held  out  1  debounced pressed level.
- short_pulse  out  1  one-cycle pulse on release of a press shorter than LONG_CYCLES.
- long_pulse  out  1  one-cycle pulse when a press reaches LONG_CYCLES.
- repeat_pulse  out  1  one-cycle pulse every REPEAT_CYCLES after long_pulse while still held.

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high. All flops clear on rst. Every output resets to 0.
- Synchronizer:
  - btn_raw (inverted if ACTIVE_LOW) passes through SYNC_STAGES flops to produce btn_sync.
  - The chain reset value is "not pressed".
- Debounce:
  - deb_cnt increments on each cycle where btn_sync != held, and clears on any cycle where they are equal.
  - When deb_cnt == DEBOUNCE_CYCLES-1 and btn_sync != held, held <= btn_sync and deb_cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes held.
- Latency: a clean raw edge appears on held after SYNC_STAGES+DEBOUNCE_CYCLES clocks. Pulses are registered and appear one clock after the FSM event.
- FSM states: IDLE, PRESSED, LONG_HELD. Counters: hold_cnt of width $clog2(LONG_CYCLES), rep_cnt of width $clog2(REPEAT_CYCLES).
  - IDLE: on held rising, go to PRESSED with hold_cnt <= 0.
  - PRESSED:
    - Each cycle, hold_cnt++.
    - If held falls, short_pulse=1 and go to IDLE.
    - Else if hold_cnt == LONG_CYCLES-1, long_pulse=1, rep_cnt <= 0, go to LONG_HELD.
  - LONG_HELD:
    - Each cycle, rep_cnt++. At rep_cnt == REPEAT_CYCLES-1, repeat_pulse=1 and rep_cnt <= 0.
    - If held falls, go to IDLE with no pulse. A fall takes priority over a repeat in the same cycle.
- Simultaneous events:
  - A fall in the same cycle as hold_cnt reaching LONG_CYCLES-1 counts as a short press: short_pulse only.
  - At most one pulse output is high in any cycle.
- ena low:
  - FSM goes to IDLE and counters clear; pulses are 0 from the next edge.
  - Synchronizer and debounce keep running, so held stays valid.
  - When ena rises while held=1, nothing fires until held falls and rises again: IDLE requires a rising edge.
- Reset mid-press: all state clears immediately.
  - After rst deasserts with the button still pressed, held rises after the full debounce time, giving a fresh press.
- Counters never wrap: hold_cnt stops at the LONG transition and rep_cnt reloads at its terminal value.

Decomposition:
- Shared package button_pkg:
  - state enum gesture_state_t {IDLE, PRESSED, LONG_HELD};
  - default timing constants for the 10 MHz TT clock: DEB_10MS, LONG_500MS, REP_100MS.
- One sub-module, btn_conditioner: synchronizer plus debounce counter.
  - Parameters SYNC_STAGES, DEBOUNCE_CYCLES, ACTIVE_LOW.
  - Output is the held level.
  - The top contains only the FSM and the pulse registers.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=5, ACTIVE_LOW=0):
- Reset and glitch:
  - Hold rst for 3 clocks, then release: all outputs 0.
  - btn_raw high for 3 clocks, then low: held stays 0 and no pulses.
- Short press:
  - btn_raw rises at clock 0: held=1 at clock 6.
  - Release after 6 high clocks: exactly one short_pulse, 1 clock after held falls. long_pulse never fires.
- Long press with repeat:
  - Hold 30 clocks: one long_pulse 10 clocks after held rises, then repeat_pulse every 5 clocks.
  - On release: no short_pulse.
- Bounce: toggle btn_raw every clock for 8 clocks, then hold high → held rises once, 6 clocks after the final edge.
- Boundary: release timed so held falls on the cycle hold_cnt==9 → short_pulse only, long_pulse=0.
- ena and reset:
  - Deassert ena during LONG_HELD: repeats stop next clock and held stays 1. Reassert with the button still held: no pulses.
  - Assert rst mid-press: outputs clear asynchronously.
